bnn_cmd_loader: RTL and testbench

//  Clocked command/byte-stream front end for the BNN core.
//  - Parses an 8-bit opcode stream from the host SPI bridge.
//  - Loads the input, weight and bias vectors into double-buffered registers.
//  - Launches an inference and returns the result to the host bridge.
//  - Sits between the SPI byte interface and bnn_mlp. Generalises fixed-width byte-packing into parametrised vector widths with valid/ready flow control.

---
 rtl/bnn_cmd_loader.sv | 186 ++++++++++++++++++
 tb/tb_bnn_cmd_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bnn_cmd_loader.sv
// Byte-stream command loader for the BNN core: parses host opcodes,
// double-buffers input/weight/bias vectors, runs the core, returns result.
// Ports:
//   clk, rst_n (async, active low)
//   cmd_valid/cmd_ready/cmd_data : host byte stream
//   bnn_input/bnn_weights/bnn_bias : live vectors
//   bnn_start, bnn_done, bnn_result : core handshake
//   res_valid/res_data : result strobe
//   err : one-cycle error pulse
// Optional: define BNN_LOADER_CKSUM_EN to require an XOR check byte.
module bnn_cmd_loader #(
  parameter int IN_BITS  = 4,
  parameter int W_BITS   = 16,
  parameter int B_BITS   = 16,
  parameter int RES_BITS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [7:0]          cmd_data,
  output logic [IN_BITS-1:0]  bnn_input,
  output logic [W_BITS-1:0]   bnn_weights,
  output logic [B_BITS-1:0]   bnn_bias,
  output logic                bnn_start,
  input  logic                bnn_done,
  input  logic [RES_BITS-1:0] bnn_result,
  output logic                res_valid,
  output logic [7:0]          res_data,
  output logic                err
);

  typedef enum logic [2:0] {
    IDLE, LOAD, CHK, RUN, WAIT, RESP
  } state_t;

  typedef enum logic [1:0] {
    T_IN, T_W, T_B
  } tgt_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state;
  tgt_t          tgt;
  logic [2:0]    cnt;
  logic [63:0]   shadow;
  logic [63:0]   next_shadow;
  logic [63:0]   commit_vec;
  logic [7:0]    csum;
  logic [TW-1:0] tmo;
  logic          acc;
  logic          last;
  logic          do_commit;
  logic          do_clear;

  function automatic logic [2:0] last_idx(input tgt_t t);
    unique case (t)
      T_IN:    return 3'((IN_BITS + 7) / 8 - 1);
      T_W:     return 3'((W_BITS + 7) / 8 - 1);
      default: return 3'((B_BITS + 7) / 8 - 1);
    endcase
  endfunction

  assign acc  = cmd_valid && cmd_ready;
  assign last = (cnt == last_idx(tgt));

  always_comb begin
    next_shadow = shadow;
    next_shadow[{cnt, 3'b000} +: 8] = cmd_data;
  end

  // Live vectors only change on a complete (and checked) payload.
  always_comb begin
    do_clear   = acc && (state == IDLE) && (cmd_data == 8'h00);
`ifdef BNN_LOADER_CKSUM_EN
    commit_vec = shadow;
    do_commit  = acc && (state == CHK) && (cmd_data == csum);
`else
    commit_vec = next_shadow;
    do_commit  = acc && (state == LOAD) && last;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bnn_input   <= '0;
      bnn_weights <= '0;
      bnn_bias    <= '0;
    end else if (do_clear) begin
      bnn_input   <= '0;
      bnn_weights <= '0;
      bnn_bias    <= '0;
    end else if (do_commit) begin
      unique case (tgt)
        T_IN:    bnn_input   <= commit_vec[IN_BITS-1:0];
        T_W:     bnn_weights <= commit_vec[W_BITS-1:0];
        default: bnn_bias    <= commit_vec[B_BITS-1:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tgt       <= T_IN;
      cnt       <= '0;
      shadow    <= '0;
      csum      <= '0;
      tmo       <= '0;
      cmd_ready <= 1'b0;
      bnn_start <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      err       <= 1'b0;
    end else begin
      bnn_start <= 1'b0;
      res_valid <= 1'b0;
      err       <= 1'b0;
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (acc) begin
            unique case (cmd_data)
              8'hB1, 8'hB2, 8'hB3: begin
                state  <= LOAD;
                tgt    <= tgt_t'(cmd_data[1:0] - 2'd1);
                cnt    <= '0;
                shadow <= '0;
                csum   <= '0;
                tmo    <= '0;
              end
              8'hB4: begin
                state     <= RUN;
                cmd_ready <= 1'b0;
                bnn_start <= 1'b1;
              end
              8'h00:   ;
              default: err <= 1'b1;
            endcase
          end
        end
        LOAD, CHK: begin
          // An accepted byte always beats timeout expiry.
          if (acc) begin
            tmo <= '0;
            if (state == CHK) begin
              err   <= !do_commit;
              state <= IDLE;
            end else begin
              shadow <= next_shadow;
              csum   <= csum ^ cmd_data;
              cnt    <= cnt + 3'd1;
              if (last) begin
`ifdef BNN_LOADER_CKSUM_EN
                state <= CHK;
`else
                state <= IDLE;
`endif
              end
            end
          end else if (tmo == TW'(TIMEOUT - 1)) begin
            err   <= 1'b1;
            state <= IDLE;
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        RUN: state <= WAIT;
        WAIT: begin
          if (bnn_done) begin
            res_data  <= 8'(bnn_result);
            res_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_cmd_loader.sv
// Directed self-checking bench for bnn_cmd_loader.
// Drives on negedge, samples on negedge one cycle after accept edges.
module tb_bnn_cmd_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_data = '0;
  logic [3:0]  bnn_input;
  logic [15:0] bnn_weights;
  logic [15:0] bnn_bias;
  logic        bnn_start;
  logic        bnn_done = 1'b0;
  logic [3:0]  bnn_result = '0;
  logic        res_valid;
  logic [7:0]  res_data;
  logic        err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bnn_cmd_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .bnn_input   (bnn_input),
    .bnn_weights (bnn_weights),
    .bnn_bias    (bnn_bias),
    .bnn_start   (bnn_start),
    .bnn_done    (bnn_done),
    .bnn_result  (bnn_result),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .err         (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = b;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("ready_wait", {63'd0, cmd_ready}, 64'd1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 cmd_valid = 1'b0;
    end
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_ready", cmd_ready, 0);
    chk("rst_in", bnn_input, 0);
    chk("rst_w", bnn_weights, 0);
    chk("rst_b", bnn_bias, 0);
    chk("rst_start", bnn_start, 0);
    chk("rst_rv", res_valid, 0);
    chk("rst_rd", res_data, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rel_ready0", cmd_ready, 0);
    @(negedge clk);
    chk("rel_ready1", cmd_ready, 1);

    // 1: weights, no partial vector
    send(8'hB2);
    send(8'h34);
    @(negedge clk);
    chk("w_partial", bnn_weights, 16'h0000);
    send(8'h12);
`ifdef BNN_LOADER_CKSUM_EN
    @(negedge clk);
    chk("w_partial2", bnn_weights, 16'h0000);
    send(8'h26);
`endif
    @(negedge clk);
    chk("w_commit", bnn_weights, 16'h1234);
    chk("w_noerr", err, 0);

    // 2: input then run
    send(8'hB1);
    send(8'h05);
`ifdef BNN_LOADER_CKSUM_EN
    send(8'h05);
`endif
    @(negedge clk);
    chk("in5", bnn_input, 4'h5);
    bnn_done   = 1'b1;
    bnn_result = 4'h7;
    @(negedge clk);
    bnn_done = 1'b0;
    chk("idle_done_rv", res_valid, 0);
    send(8'hB4);
    @(negedge clk);
    chk("run_start", bnn_start, 1);
    chk("run_ready", cmd_ready, 0);
    @(negedge clk);
    chk("wait1_start", bnn_start, 0);
    chk("wait1_ready", cmd_ready, 0);
    chk("wait1_rv", res_valid, 0);
    @(negedge clk);
    chk("wait2_ready", cmd_ready, 0);
    bnn_done   = 1'b1;
    bnn_result = 4'hA;
    @(negedge clk);
    bnn_done = 1'b0;
    chk("resp_rv", res_valid, 1);
    chk("resp_rd", res_data, 8'h0A);
    chk("resp_ready", cmd_ready, 0);
    chk("resp_start", bnn_start, 0);
    @(negedge clk);
    chk("post_rv", res_valid, 0);
    chk("post_ready", cmd_ready, 1);

    // 3: bad opcode
    send(8'h7F);
    @(negedge clk);
    chk("bad_err", err, 1);
    chk("bad_in", bnn_input, 4'h5);
    chk("bad_w", bnn_weights, 16'h1234);
    chk("bad_b", bnn_bias, 16'h0000);
    @(negedge clk);
    chk("bad_err_off", err, 0);
    send(8'hB1);
    send(8'h03);
`ifdef BNN_LOADER_CKSUM_EN
    send(8'h03);
`endif
    @(negedge clk);
    chk("in3", bnn_input, 4'h3);

    // 4: timeout keeps old bias
    send(8'hB3);
    send(8'hCD);
    send(8'hAB);
`ifdef BNN_LOADER_CKSUM_EN
    send(8'h66);
`endif
    @(negedge clk);
    chk("b_commit", bnn_bias, 16'hABCD);
    send(8'hB3);
    send(8'hFF);
    repeat (255) @(negedge clk);
    chk("tmo_early", err, 0);
    @(negedge clk);
    chk("tmo_err", err, 1);
    chk("tmo_bias", bnn_bias, 16'hABCD);
    @(negedge clk);
    chk("tmo_err_off", err, 0);
    send(8'hB1);
    send(8'h09);
`ifdef BNN_LOADER_CKSUM_EN
    send(8'h09);
`endif
    @(negedge clk);
    chk("tmo_idle_in", bnn_input, 4'h9);
    chk("tmo_idle_b", bnn_bias, 16'hABCD);

    // 5: reset mid-WAIT
    send(8'hB4);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    bnn_done   = 1'b1;
    bnn_result = 4'hC;
    #1;
    chk("ar_in", bnn_input, 0);
    chk("ar_w", bnn_weights, 0);
    chk("ar_b", bnn_bias, 0);
    chk("ar_ready", cmd_ready, 0);
    chk("ar_start", bnn_start, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ar_no_rv", res_valid, 0);
      chk("ar_no_err", err, 0);
    end
    bnn_done = 1'b0;
    chk("ar_ready1", cmd_ready, 1);

    // clear opcode
    send(8'hB1);
    send(8'h06);
`ifdef BNN_LOADER_CKSUM_EN
    send(8'h06);
`endif
    @(negedge clk);
    chk("clr_pre", bnn_input, 4'h6);
    send(8'h00);
    @(negedge clk);
    chk("clr_in", bnn_input, 0);
    chk("clr_err", err, 0);

`ifdef BNN_LOADER_CKSUM_EN
    // 6: checksum mismatch
    send(8'hB2);
    send(8'h34);
    send(8'h12);
    send(8'h26);
    @(negedge clk);
    chk("ck_ok", bnn_weights, 16'h1234);
    send(8'hB2);
    send(8'h78);
    send(8'h56);
    send(8'h00);
    @(negedge clk);
    chk("ck_bad_err", err, 1);
    chk("ck_bad_w", bnn_weights, 16'h1234);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
